wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Writer-side companion to the register file write port; the single producer of RegWrite, Write_register and Write_data.
- Merges two result sources onto the one write port:
  - the in-order pipeline WB stage, which has priority;
  - a multi-cycle unit (mul/div) delivering results through a valid/ready handshake into an internal FIFO.
- Keeps a busy scoreboard of registers with outstanding multi-cycle results and raises a decode-stage stall on RAW/WAW hazards against them.

Parameters:
- DEPTH, 4, multi-cycle result FIFO entries; power of two, 2..16.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock, all state updates on the posedge.
- reset  in  1  asynchronous, active-high.
- wb_valid  in  1  pipeline WB result valid this cycle.
- wb_reg  in  5  pipeline destination register.
- wb_data  in  32  pipeline result.
- md_issue  in  1  multi-cycle op issued this cycle.
- md_issue_reg  in  5  its destination register.
- md_valid  in  1  multi-cycle result valid.
- md_ready  out  1  FIFO can accept a result.
- md_reg  in  5  result destination register.
- md_data  in  32  result data.
- id_rs1  in  5  decode-stage source register 1.
- id_rs2  in  5  decode-stage source register 2.
- id_rd  in  5  decode-stage destination register.
- id_rd_we  in  1  decode instruction writes id_rd.
- stall  out  1  hazard against an outstanding multi-cycle result.
- RegWrite  out  1  register file write enable (registered).
- Write_register  out  5  register file write address (registered).
- Write_data  out  32  register file write data (registered).
- fifo_count  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous and active-high:
  - RegWrite=0, Write_register=0, Write_data=0.
  - FIFO empty, fifo_count=0, all busy bits 0.
  - md_ready=0 while reset is asserted.
  - Reset mid-operation discards all queued results and busy bits.
- md_ready = !reset && (fifo_count != DEPTH). A result is accepted on a posedge with md_valid && md_ready. md_reg==0 results are accepted and dropped, not enqueued.
- Arbitration, evaluated each cycle, takes effect at the next posedge:
  - wb_valid=1 and wb_reg!=0: outputs load {1, wb_reg, wb_data}; the FIFO does not pop.
  - wb_valid=1 and wb_reg==0: treated as no pipeline write; FIFO may pop.
  - Otherwise, if the FIFO is non-empty: pop the head and load {1, head.reg, head.data}.
  - Otherwise: RegWrite loads 0; Write_register and Write_data hold their values.
- Latency:
  - Pipeline write appears on the port 1 cycle after wb_valid.
  - FIFO result accepted at edge N is written at the earliest in the cycle after edge N+1.
  - No FIFO bypass.
- Push and pop on the same edge are allowed; fifo_count is unchanged. Pointers wrap modulo DEPTH.
- Scoreboard busy[31:1]:
  - Set on a posedge with md_issue && md_issue_reg!=0.
  - Cleared on the posedge where a FIFO pop loads that register onto the port.
  - Set and clear of the same register on the same edge: set wins.
  - Pipeline writes never touch busy bits.
- stall (combinational) = busy[id_rs1] | busy[id_rs2] | (id_rd_we & busy[id_rd]). Register 0 is never busy.
- Ordering guarantee: results from the multi-cycle unit retire in FIFO order. The arbiter imposes no ordering between pipeline writes and FIFO writes; the stall prevents conflicts.

Test Plan:
- Reset: assert reset with md_valid=1 → RegWrite=0, md_ready=0, fifo_count=0, stall=0. Deassert → md_ready=1.
- Pipeline only: wb_valid=1, wb_reg=5, wb_data=0x1234 → next cycle RegWrite=1, Write_register=5, Write_data=0x1234. wb_reg=0 gives RegWrite=0.
- Multi-cycle path and scoreboard:
  - md_issue reg 7 → stall=1 for id_rs1=7 and for id_rd=7 with id_rd_we=1; stall=0 for id_rd=7 with id_rd_we=0.
  - Then md_valid, md_reg=7, data 0xCAFEBABE, with wb idle → write reg 7 two cycles after acceptance; busy[7] clears and stall drops.
- Priority and backpressure: hold wb_valid=1 (regs 1..) while pushing 5 md results → md_ready=0 after 4 accepted, fifo_count=4. Release wb → FIFO drains one write per cycle in order, and md_ready returns after the first pop.
- Same-edge set/clear: pop of reg 9 coincides with md_issue reg 9 → busy[9] remains 1.
- Wrap-around and reset mid-queue:
  - Push/pop 10 results with DEPTH=4 → data and order intact.
  - Assert reset with 3 queued → queue lost, no further writes after release.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register file write-port arbiter. The WB stage has priority on the single
// write port; multi-cycle (mul/div) results queue in a small FIFO and drain
// when the pipeline is not writing. A busy scoreboard tracks destinations
// with results still outstanding from the multi-cycle unit and drives the
// decode-stage stall.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [4:0]    wb_reg,
  input  logic [31:0]   wb_data,
  input  logic          md_issue,
  input  logic [4:0]    md_issue_reg,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [4:0]    md_reg,
  input  logic [31:0]   md_data,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic [4:0]    id_rd,
  input  logic          id_rd_we,
  output logic          stall,
  output logic          RegWrite,
  output logic [4:0]    Write_register,
  output logic [31:0]   Write_data,
  output logic [AW:0]   fifo_count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // FIFO storage carries no reset; only pointers and occupancy are control.
  logic [4:0]    freg_q  [DEPTH];
  logic [31:0]   fdata_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q,  count_d;
  logic [31:1]   busy_q;
  logic [31:0]   busy_d;
  logic [31:0]   busy_all;

  logic          we_q;
  logic [4:0]    wreg_q;
  logic [31:0]   wdata_q;

  logic          wb_take;
  logic          accept;
  logic          push;
  logic          pop;
  logic [4:0]    head_reg;

  assign md_ready = !reset && (count_q != FULL);
  assign accept   = md_valid && md_ready;
  // Results for x0 complete the handshake but are never stored.
  assign push     = accept && (md_reg != 5'd0);
  assign wb_take  = wb_valid && (wb_reg != 5'd0);
  assign pop      = !wb_take && (count_q != '0);
  assign head_reg = freg_q[rd_ptr_q];

  assign busy_all = {busy_q, 1'b0};
  assign stall    = busy_all[id_rs1] | busy_all[id_rs2] | (id_rd_we & busy_all[id_rd]);

  assign RegWrite       = we_q;
  assign Write_register = wreg_q;
  assign Write_data     = wdata_q;
  assign fifo_count     = count_q;

  // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  // Scoreboard next state: clear on retire, then set on issue so set wins.
  always_comb begin
    busy_d = busy_all;
    if (pop)
      busy_d[head_reg] = 1'b0;
    if (md_issue && (md_issue_reg != 5'd0))
      busy_d[md_issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Result FIFO payload capture.
  always_ff @(posedge clk) begin
    if (push) begin
      freg_q[wr_ptr_q]  <= md_reg;
      fdata_q[wr_ptr_q] <= md_data;
    end
  end

  // FIFO pointers, occupancy and busy scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      busy_q  <= busy_d[31:1];
    end
  end

  // Registered write port: pipeline first, then FIFO head, else idle (hold addr/data).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= 32'd0;
    end else if (wb_take) begin
      we_q    <= 1'b1;
      wreg_q  <= wb_reg;
      wdata_q <= wb_data;
    end else if (pop) begin
      we_q    <= 1'b1;
      wreg_q  <= head_reg;
      wdata_q <= fdata_q[rd_ptr_q];
    end else begin
      we_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the write port.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [4:0]    wb_reg;
  logic [31:0]   wb_data;
  logic          md_issue;
  logic [4:0]    md_issue_reg;
  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_reg;
  logic [31:0]   md_data;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_rd_we;
  logic          stall;
  logic          RegWrite;
  logic [4:0]    Write_register;
  logic [31:0]   Write_data;
  logic [AW:0]   fifo_count;

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_issue(md_issue), .md_issue_reg(md_issue_reg),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .stall(stall), .RegWrite(RegWrite), .Write_register(Write_register),
    .Write_data(Write_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: queued results, busy set, expected port contents.
  logic [36:0] mq[$];
  logic [31:0] mbusy;
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic        m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_stall();
    return mbusy[id_rs1] | mbusy[id_rs2] | (id_rd_we & mbusy[id_rd]);
  endfunction

  task automatic model_reset();
    mq.delete();
    mbusy = '0;
    m_we  = 1'b0;
    m_wr  = '0;
    m_wd  = '0;
    m_acc = 1'b0;
  endtask

  task automatic model_step();
    logic [36:0] e;
    logic        wbw;
    wbw   = wb_valid && (wb_reg != 5'd0);
    m_acc = md_valid && (mq.size() < DEPTH);
    if (wbw) begin
      m_we = 1'b1; m_wr = wb_reg; m_wd = wb_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_wr = e[36:32]; m_wd = e[31:0];
      mbusy[e[36:32]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (m_acc && (md_reg != 5'd0))
      mq.push_back({md_reg, md_data});
    if (md_issue && (md_issue_reg != 5'd0))
      mbusy[md_issue_reg] = 1'b1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    md_issue = 0; md_issue_reg = 0;
    md_valid = 0; md_reg = 0; md_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_we = 0;
  endtask

  // One clock: inputs already applied at the negedge.
  task automatic cycle();
    #1;
    if (reset) model_reset();
    check("md_ready",   32'(md_ready),   32'(!reset && (mq.size() != DEPTH)));
    check("fifo_count", 32'(fifo_count), mq.size());
    check("stall",      32'(stall),      32'(exp_stall()));
    if (!reset) model_step();
    else m_acc = 1'b0;
    @(posedge clk);
    #1;
    check("RegWrite",       32'(RegWrite),       32'(m_we));
    check("Write_register", 32'(Write_register), 32'(m_wr));
    check("Write_data",     Write_data,          m_wd);
    @(negedge clk);
  endtask

  initial begin
    int k;
    model_reset();
    idle();
    reset = 1'b0;
    @(negedge clk);

    // Reset with a result offered: nothing may be accepted.
    reset = 1'b1; md_valid = 1; md_reg = 5'd3; md_data = 32'h11;
    #1;
    check("rst_regwrite", 32'(RegWrite),   0);
    check("rst_ready",    32'(md_ready),   0);
    check("rst_count",    32'(fifo_count), 0);
    check("rst_stall",    32'(stall),      0);
    cycle();
    reset = 1'b0; idle();
    #1 check("ready_after_rst", 32'(md_ready), 1);
    cycle();

    // Pipeline-only writes.
    wb_valid = 1; wb_reg = 5'd5; wb_data = 32'h1234;
    cycle();
    check("wb_we",   32'(RegWrite), 1);
    check("wb_reg",  32'(Write_register), 5);
    check("wb_data", Write_data, 32'h1234);
    wb_reg = 5'd0; wb_data = 32'h9999;
    cycle();
    check("wb_x0_we", 32'(RegWrite), 0);

    // Multi-cycle issue, hazard detection, then completion.
    idle(); md_issue = 1; md_issue_reg = 5'd7;
    cycle();
    idle(); id_rs1 = 5'd7;
    #1 check("stall_rs1", 32'(stall), 1);
    id_rs1 = 0; id_rd = 5'd7; id_rd_we = 1;
    #1 check("stall_rd_we", 32'(stall), 1);
    id_rd_we = 0;
    #1 check("stall_rd_nowe", 32'(stall), 0);
    cycle();
    md_valid = 1; md_reg = 5'd7; md_data = 32'hCAFEBABE;
    cycle();
    check("md_not_bypassed", 32'(RegWrite), 0);
    idle(); id_rs1 = 5'd7;
    cycle();
    check("md_we",   32'(RegWrite), 1);
    check("md_reg",  32'(Write_register), 7);
    check("md_data", Write_data, 32'hCAFEBABE);
    #1 check("stall_cleared", 32'(stall), 0);
    idle();
    cycle();

    // Priority and backpressure: pipeline blocks the FIFO while 5 results are offered.
    k = 0;
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1; wb_reg = 5'(1 + i); wb_data = $urandom;
      md_valid = 1; md_reg = 5'(10 + k); md_data = $urandom;
      cycle();
      if (m_acc) k++;
    end
    #1;
    check("bp_count", 32'(fifo_count), 4);
    check("bp_ready", 32'(md_ready),   0);
    wb_valid = 0; wb_reg = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (m_acc) md_valid = 0;
    end
    idle();
    cycle();

    // Retire of reg 9 coincides with a new issue to reg 9: stays busy.
    md_issue = 1; md_issue_reg = 5'd9;
    cycle();
    idle(); md_valid = 1; md_reg = 5'd9; md_data = 32'h99;
    cycle();
    idle(); md_issue = 1; md_issue_reg = 5'd9;
    cycle();
    check("same_edge_pop", 32'(Write_register), 9);
    idle(); id_rs2 = 5'd9;
    #1 check("same_edge_busy", 32'(stall), 1);
    cycle();

    // Wrap-around: ten back-to-back results with simultaneous push/pop.
    for (int i = 0; i < 10; i++) begin
      idle(); md_valid = 1; md_reg = 5'(1 + i); md_data = $urandom;
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) cycle();

    // Reset with three queued results.
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_reg = 5'd2; wb_data = $urandom;
      md_valid = 1; md_reg = 5'(20 + i); md_data = $urandom;
      cycle();
    end
    idle(); reset = 1'b1;
    cycle();
    check("rst_mid_count", 32'(fifo_count), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rst_mid_nowrite", 32'(RegWrite), 0);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      wb_valid     = ($urandom_range(0, 99) < 55);
      wb_reg       = 5'($urandom_range(0, 31));
      wb_data      = $urandom;
      md_issue     = ($urandom_range(0, 99) < 30);
      md_issue_reg = 5'($urandom_range(0, 31));
      md_valid     = ($urandom_range(0, 99) < 50);
      md_reg       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      md_data      = $urandom;
      id_rs1       = 5'($urandom_range(0, 31));
      id_rs2       = 5'($urandom_range(0, 31));
      id_rd        = 5'($urandom_range(0, 31));
      id_rd_we     = 1'($urandom_range(0, 1));
      cycle();
    end
    reset = 1'b0; idle();
    for (int i = 0; i < 6; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
